// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg                                                             |
// | Shared receiver state encoding and oversampling constants.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    localparam int OVERSAMPLE  = 16;
    localparam int MID_SAMPLE  = 7;
    localparam int LAST_SAMPLE = 15;
    localparam int DATA_BITS   = 8;

    localparam int SCNT_W = $clog2(OVERSAMPLE);
    localparam int BIDX_W = $clog2(DATA_BITS);

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_baud_tick                                                       |
// | Free-running divider; tick is high for one clk every DIV clocks.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_baud_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_receiver                                                        |
// | 16x oversampled 8N1 UART receiver with holding register, glitch,     |
// | framing and overrun detection. UART_RX_PARITY_EN adds even parity.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 115200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);

    localparam logic [SCNT_W-1:0] MID_S    = SCNT_W'(MID_SAMPLE);
    localparam logic [SCNT_W-1:0] LAST_S   = SCNT_W'(LAST_SAMPLE);
    localparam logic [BIDX_W-1:0] LAST_BIT = BIDX_W'(DATA_BITS - 1);

    generate
        if (DIV < 1) begin : g_div_check
            $error("uart_receiver: CLK_HZ/(BAUD*16) must be at least 1");
        end
    endgenerate

    logic                 sync1;
    logic                 rx_s;
    logic                 tick;
    state_t               state, state_next;
    logic [SCNT_W-1:0]    scnt, scnt_next;
    logic [BIDX_W-1:0]    bidx, bidx_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic                 byte_done;
    logic                 stop_bad;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad, par_bad_next;
    logic                 par_err_set;
`endif

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= uart_rx;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            scnt  <= '0;
            bidx  <= '0;
            shreg <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            state <= state_next;
            scnt  <= scnt_next;
            bidx  <= bidx_next;
            shreg <= shreg_next;
`ifdef UART_RX_PARITY_EN
            par_bad <= par_bad_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        scnt_next  = scnt;
        bidx_next  = bidx;
        shreg_next = shreg;
        byte_done  = 1'b0;
        stop_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_next = par_bad;
        par_err_set  = 1'b0;
`endif
        if (tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_next = START;
                        scnt_next  = '0;
                    end
                end
                START: begin
                    if (scnt == MID_S) begin
                        scnt_next  = '0;
                        bidx_next  = '0;
                        state_next = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
                        par_bad_next = 1'b0;
`endif
                    end else begin
                        scnt_next = scnt + 1'b1;
                    end
                end
                DATA: begin
                    if (scnt == LAST_S) begin
                        scnt_next        = '0;
                        shreg_next[bidx] = rx_s;
                        if (bidx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            bidx_next = bidx + 1'b1;
                        end
                    end else begin
                        scnt_next = scnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (scnt == LAST_S) begin
                        scnt_next    = '0;
                        par_bad_next = rx_s ^ (^shreg);
                        par_err_set  = rx_s ^ (^shreg);
                        state_next   = STOP;
                    end else begin
                        scnt_next = scnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (scnt == LAST_S) begin
                        scnt_next = '0;
                        if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                            byte_done = !par_bad;
`else
                            byte_done = 1'b1;
`endif
                            state_next = IDLE;
                        end else begin
                            stop_bad   = 1'b1;
                            state_next = BREAK;
                        end
                    end else begin
                        scnt_next = scnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // A completion coinciding with a consumer read refills the register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= byte_done && rx_valid && !rx_ready;
            if (byte_done && !(rx_valid && !rx_ready)) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= par_err_set;
        end
    end
`endif

    assign rx_busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_receiver                                                     |
// | Directed scoreboard bench for uart_receiver (DIV=4, 64 clk per bit). |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uart_receiver;

    localparam int CLK_HZ   = 64;
    localparam int BAUD     = 1;
    localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CLKS = FRAME_BITS * BIT_CLKS;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       uart_rx  = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    logic       par_flip = 1'b0;
    int         pe_cnt   = 0;
    logic       prev_pe  = 1'b0;
`endif

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         rise_cyc = 0;
    int         ready_at = -1;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         wide_cnt = 0;
    logic       prev_valid = 1'b0;
    logic       prev_fe = 1'b0;
    logic       prev_ov = 1'b0;
    logic [7:0] exp_q[$];

    uart_receiver #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, count pulses, then drive rx_ready.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (rx_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = rx_valid;
        if (frame_err) fe_cnt++;
        if (frame_err && prev_fe) wide_cnt++;
        prev_fe = frame_err;
        if (overrun) ov_cnt++;
        if (overrun && prev_ov) wide_cnt++;
        prev_ov = overrun;
`ifdef UART_RX_PARITY_EN
        if (parity_err) pe_cnt++;
        if (parity_err && prev_pe) wide_cnt++;
        prev_pe = parity_err;
`endif
        rx_ready = (cyc == ready_at);
    endtask

    task automatic hold(input logic lvl, input int n);
        uart_rx = lvl;
        repeat (n) step();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        hold(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) hold(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
        hold((^d) ^ par_flip, BIT_CLKS);
`endif
        hold(stop_bit, BIT_CLKS);
        uart_rx = 1'b1;
    endtask

    task automatic pop_check(input string name);
        int n = 0;
        while (!rx_valid && n < 2000) begin
            step();
            n++;
        end
        check({name, "_valid"}, {31'd0, rx_valid}, 32'd1);
        check({name, "_sb_nonempty"}, {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) check(name, {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
    endtask

    task automatic consume();
        ready_at = cyc + 1;
        step();
        step();
    endtask

    initial begin
        int   fe0, ov0;
        logic busy_seen;

        // Reset state
        repeat (3) step();
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_busy", {31'd0, rx_busy}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        rst = 1'b1;
        hold(1'b1, 20);

        // 1: single byte, held until consumed
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        pop_check("t1_data");
        hold(1'b1, 50);
        check("t1_hold_valid", {31'd0, rx_valid}, 32'd1);
        check("t1_hold_data", {24'd0, rx_data}, 32'hA5);
        consume();
        check("t1_clear", {31'd0, rx_valid}, 32'd0);
        hold(1'b1, 20);

        // 2: short low glitch is rejected
        fe0 = fe_cnt;
        busy_seen = 1'b0;
        uart_rx = 1'b0;
        repeat (16) begin step(); busy_seen |= rx_busy; end
        uart_rx = 1'b1;
        repeat (60) begin step(); busy_seen |= rx_busy; end
        check("t2_busy_seen", {31'd0, busy_seen}, 32'd1);
        check("t2_busy_end", {31'd0, rx_busy}, 32'd0);
        check("t2_no_valid", {31'd0, rx_valid}, 32'd0);
        check("t2_no_ferr", fe_cnt, fe0);

        // 3: framing error followed by a break
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        hold(1'b0, 200);
        check("t3_busy_hold", {31'd0, rx_busy}, 32'd1);
        check("t3_ferr", fe_cnt, fe0 + 1);
        check("t3_no_valid", {31'd0, rx_valid}, 32'd0);
        hold(1'b1, 12);
        check("t3_busy_end", {31'd0, rx_busy}, 32'd0);
        hold(1'b1, 64);

        // 4: back-to-back with full holding register -> overrun
        ov0 = ov_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        pop_check("t4_first");
        send_frame(8'h22, 1'b1);
        check("t4_overrun", ov_cnt, ov0 + 1);
        check("t4_keep_data", {24'd0, rx_data}, 32'h11);
        check("t4_keep_valid", {31'd0, rx_valid}, 32'd1);
        consume();
        check("t4_drain", {31'd0, rx_valid}, 32'd0);
        hold(1'b1, 64);

        // 5: read in the exact completion cycle of the second byte
        ov0 = ov_cnt;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b1);
        pop_check("t5_first");
        ready_at = rise_cyc - 1 + FRAME_CLKS;
        send_frame(8'h22, 1'b1);
        pop_check("t5_second");
        check("t5_no_overrun", ov_cnt, ov0);

        // 6: reset during data bit 4 aborts the frame quietly
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        hold(1'b0, BIT_CLKS);
        hold(1'b0, BIT_CLKS);
        hold(1'b1, BIT_CLKS);
        hold(1'b1, BIT_CLKS);
        hold(1'b0, BIT_CLKS);
        hold(1'b1, BIT_CLKS / 2);
        rst = 1'b0;
        uart_rx = 1'b1;
        step();
        check("t6_rst_data", {24'd0, rx_data}, 32'd0);
        check("t6_rst_valid", {31'd0, rx_valid}, 32'd0);
        check("t6_rst_busy", {31'd0, rx_busy}, 32'd0);
        check("t6_rst_ferr", {31'd0, frame_err}, 32'd0);
        check("t6_rst_ovr", {31'd0, overrun}, 32'd0);
        hold(1'b1, 10);
        rst = 1'b1;
        hold(1'b1, 64);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        pop_check("t6_data");
        check("t6_no_ferr", fe_cnt, fe0);
        check("t6_no_ovr", ov_cnt, ov0);
        consume();
        hold(1'b1, 20);

`ifdef UART_RX_PARITY_EN
        // 7: bad parity discards the byte
        begin
            int pe0;
            pe0 = pe_cnt;
            par_flip = 1'b1;
            send_frame(8'h01, 1'b1);
            par_flip = 1'b0;
            hold(1'b1, 20);
            check("t7_perr", pe_cnt, pe0 + 1);
            check("t7_no_valid", {31'd0, rx_valid}, 32'd0);
        end
`endif

        check("pulse_width", wide_cnt, 0);
        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
